// File: rtl/fpu_mant_mult_pkg.sv
// rtl/fpu_mant_mult_pkg.sv - shared constants and state type for the mantissa multiplier
package fpu_mant_mult_pkg;
    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/fpu_mant_mult_if.sv
// rtl/fpu_mant_mult_if.sv - request/result bundle between the FPU and the mantissa multiplier
interface fpu_mant_mult_if;
    import fpu_mant_mult_pkg::*;

    logic              start;
    logic              flush;
    logic [MANT_W-1:0] opa_man;
    logic [MANT_W-1:0] opb_man;
    logic [PROD_W-1:0] product;
    logic              busy;
    logic              done;

    modport master (output start, flush, opa_man, opb_man, input product, busy, done);
    modport slave  (input start, flush, opa_man, opb_man, output product, busy, done);
endinterface

// File: rtl/fpu_mant_mult_pp.sv
// rtl/fpu_mant_mult_pp.sv - combinational partial product of A and one multiplier digit
module fpu_mant_pp
    import fpu_mant_mult_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [MANT_W-1:0]                a_i,
    input  logic [BITS_PER_CYCLE-1:0]        digit_i,
    output logic [MANT_W+BITS_PER_CYCLE-1:0] pp_o
);
    assign pp_o = {{BITS_PER_CYCLE{1'b0}}, a_i} * {{MANT_W{1'b0}}, digit_i};
endmodule

// File: rtl/fpu_mant_mult.sv
// rtl/fpu_mant_mult.sv - iterative 24x24 mantissa multiplier, BITS_PER_CYCLE multiplier bits per step
module fpu_mant_mult
    import fpu_mant_mult_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    fpu_mant_mult_if.slave   bus
);
    localparam int STEPS = MANT_W / BITS_PER_CYCLE;
    localparam int PP_W  = MANT_W + BITS_PER_CYCLE;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [MANT_W-1:0] a_q;
    logic [MANT_W-1:0] b_q;
    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] product_q;
    logic              busy_q;
    logic              done_q;

    logic [PP_W-1:0]   pp;
    logic [7:0]        shamt;
    logic [PROD_W-1:0] acc_d;
    logic              zero_op;

    fpu_mant_pp #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_pp (
        .a_i     (a_q),
        .digit_i (b_q[BITS_PER_CYCLE-1:0]),
        .pp_o    (pp)
    );

    // b_q shifts right each step, so its low digit is always the next one; the
    // partial product lands at weight cnt_q * BITS_PER_CYCLE.
    assign shamt   = 8'(cnt_q) * 8'(BITS_PER_CYCLE);
    assign acc_d   = acc_q + ({{(PROD_W-PP_W){1'b0}}, pp} << shamt);
    assign zero_op = (bus.opa_man == '0) || (bus.opb_man == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            a_q   <= bus.opa_man;
                            b_q   <= bus.opb_man;
                            acc_q <= '0;
                            cnt_q <= '0;
                            if (zero_op) begin
                                state_q   <= DONE;
                                product_q <= '0;
                                done_q    <= 1'b1;
                                busy_q    <= 1'b0;
                            end else begin
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        acc_q <= acc_d;
                        b_q   <= b_q >> BITS_PER_CYCLE;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(STEPS - 1)) begin
                            state_q   <= DONE;
                            product_q <= acc_d;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_fpu_mant_mult.sv
// tb/tb_fpu_mant_mult.sv - self-checking bench for fpu_mant_mult
module tb_fpu_mant_mult;
    import fpu_mant_mult_pkg::*;

    localparam int BPC   = 2;
    localparam int STEPS = MANT_W / BPC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpu_mant_mult_if bus ();

    fpu_mant_mult #(.BITS_PER_CYCLE(BPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [PROD_W-1:0] act, input logic [PROD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a result equals A*B and becomes visible STEPS edges after an
    // accepted start (one edge for a zero operand); starts during a pending op are dropped.
    logic              m_valid = 1'b0;
    logic              m_pend  = 1'b0;
    int                m_due   = 0;
    logic [PROD_W-1:0] m_pend_prod = '0;
    logic [PROD_W-1:0] m_prod = '0;
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (!rst) begin
            m_valid = 1'b1;
            m_pend  = 1'b0;
            m_prod  = '0;
            m_busy  = 1'b0;
        end else if (bus.flush) begin
            m_pend = 1'b0;
            m_busy = 1'b0;
        end else if (m_pend) begin
            if (cyc == m_due) begin
                m_prod = m_pend_prod;
                m_done = 1'b1;
                m_busy = 1'b0;
                m_pend = 1'b0;
            end
        end else if (bus.start) begin
            if (bus.opa_man == '0 || bus.opb_man == '0) begin
                m_prod = '0;
                m_done = 1'b1;
            end else begin
                m_pend      = 1'b1;
                m_due       = cyc + STEPS;
                m_pend_prod = PROD_W'(bus.opa_man) * PROD_W'(bus.opb_man);
                m_busy      = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("done", PROD_W'(bus.done), PROD_W'(m_done));
            check("busy", PROD_W'(bus.busy), PROD_W'(m_busy));
            check("product", bus.product, m_prod);
        end
    end

    task automatic run_mul(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                           output int lat, output int bcnt);
        bit fin;
        bus.opa_man = a;
        bus.opb_man = b;
        bus.start   = 1'b1;
        lat  = 0;
        bcnt = 0;
        fin  = 1'b0;
        while (!fin) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.opa_man = MANT_W'($urandom);
            bus.opb_man = MANT_W'($urandom);
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) fin = 1'b1;
            else if (lat > 40) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done after %0d cycles expected %0d", lat, STEPS + 1);
                fin = 1'b1;
            end
        end
    endtask

    initial begin
        int lat, bcnt, dn;
        logic [MANT_W-1:0] a, b;
        logic [PROD_W-1:0] prev;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.opa_man = '0;
        bus.opb_man = '0;
        repeat (3) @(negedge clk);
        check("rst_product", bus.product, '0);
        check("rst_busy", PROD_W'(bus.busy), '0);
        rst = 1'b1;
        @(negedge clk);

        run_mul(24'h800000, 24'h800000, lat, bcnt);
        check("lat_800000", PROD_W'(lat), 48'd13);
        check("prod_800000", bus.product, 48'h400000000000);

        run_mul(24'hFFFFFF, 24'hFFFFFF, lat, bcnt);
        check("prod_ffffff", bus.product, 48'hFFFFFE000001);
        check("busy_cycles_ffffff", PROD_W'(bcnt), 48'd12);

        run_mul(24'h000000, 24'hC00000, lat, bcnt);
        check("lat_zero", PROD_W'(lat), 48'd1);
        check("busy_zero", PROD_W'(bcnt), 48'd0);
        check("prod_zero", bus.product, 48'h0);

        run_mul(24'h000001, 24'hFFFFFF, lat, bcnt);
        check("prod_one", bus.product, 48'h000000FFFFFF);
        run_mul(24'hC00000, 24'hC00000, lat, bcnt);
        check("prod_c00000", bus.product, 48'h900000000000);

        // Start held high with operands changing every cycle.
        bus.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.opa_man = MANT_W'($urandom) | 24'h800000;
            bus.opb_man = MANT_W'($urandom) | 24'h800000;
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (15) @(negedge clk);

        // Flush at RUN step 5: previous result must survive, no done.
        prev = bus.product;
        bus.opa_man = 24'h123456;
        bus.opb_man = 24'h654321;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) dn++;
            @(negedge clk);
        end
        check("flush_no_done", PROD_W'(dn), 48'd0);
        check("flush_product_kept", bus.product, prev);
        check("flush_busy", PROD_W'(bus.busy), 48'd0);

        // Flush beats a simultaneous start.
        bus.opa_man = 24'h800001;
        bus.opb_man = 24'h800001;
        bus.start   = 1'b1;
        bus.flush   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_over_start_busy", PROD_W'(bus.busy), 48'd0);
        repeat (15) @(negedge clk);

        // Reset at RUN step 5: product cleared, no done.
        bus.opa_man = 24'hABCDEF;
        bus.opb_man = 24'hFEDCBA;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) dn++;
            @(negedge clk);
        end
        check("rst_mid_no_done", PROD_W'(dn), 48'd0);
        check("rst_mid_product", bus.product, 48'h0);

        // Back-to-back random operations, each started in the previous done cycle.
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 15) == 0) ? '0 : MANT_W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : MANT_W'($urandom);
            run_mul(a, b, lat, bcnt);
            check("rand_lat", PROD_W'(lat), (a == '0 || b == '0) ? 48'd1 : PROD_W'(STEPS + 1));
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
